// File: rtl/isp_frame_ctrl_pkg.sv
// Shared types for the ISP-lite frame sequencer: FSM states and Bayer phase codes.
package isp_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2
  } frame_state_e;

  localparam logic [1:0] BAYER_RGGB = 2'd0;
  localparam logic [1:0] BAYER_GRBG = 2'd1;
  localparam logic [1:0] BAYER_GBRG = 2'd2;
  localparam logic [1:0] BAYER_BGGR = 2'd3;

endpackage

// File: rtl/isp_sync_edge.sv
// Registers one DVP control signal, keeps its previous value and derives rise/fall.
module isp_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic cur_q;
  logic prev_q;

  // Sample stage followed by the previous-value register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      cur_q  <= sig_i;
      prev_q <= cur_q;
    end
  end

  assign lvl_o  = cur_q;
  assign rise_o = cur_q & ~prev_q;
  assign fall_o = ~cur_q & prev_q;

endmodule

// File: rtl/isp_frame_ctrl.sv
// Frame-level sequencer: frame/line/pixel tracking, frame-boundary config
// shadowing and sticky geometry error flags for the ISP-lite pipeline.
module isp_frame_ctrl
  import isp_frame_ctrl_pkg::*;
#(
  parameter int         WIDTH  = 512,
  parameter int         HEIGHT = 768,
  parameter logic [1:0] BAYER  = BAYER_RGGB,
  parameter logic       EN_RST = 1'b1,
  localparam int        PW     = $clog2(WIDTH + 1),
  localparam int        LW     = $clog2(HEIGHT + 1)
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic          in_href,
  input  logic          in_vsync,
  input  logic [1:0]    cfg_bayer,
  input  logic          cfg_enable,
  input  logic          cfg_update,
  input  logic          err_clr,
  output logic [1:0]    act_bayer,
  output logic          act_enable,
  output logic          cfg_applied,
  output logic          frame_start,
  output logic          frame_done,
  output logic [15:0]   frame_cnt,
  output logic [LW-1:0] line_cnt,
  output logic [PW-1:0] pix_cnt,
  output logic          err_width,
  output logic          err_height,
  output logic          busy
);

  logic href_lvl, href_rise, href_fall;
  logic vs_lvl, vs_rise, vs_fall;

  isp_sync_edge u_href_edge (
    .clk_i (pclk),    .rst_ni (rst_n), .sig_i (in_href),
    .lvl_o (href_lvl), .rise_o (href_rise), .fall_o (href_fall)
  );

  isp_sync_edge u_vs_edge (
    .clk_i (pclk),  .rst_ni (rst_n), .sig_i (in_vsync),
    .lvl_o (vs_lvl), .rise_o (vs_rise), .fall_o (vs_fall)
  );

  frame_state_e  state_q, state_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [LW-1:0] line_q, line_d, line_inc, line_eff;
  logic [PW-1:0] pix_q, pix_d, pix_inc;
  logic          errw_q, errw_d, errh_q, errh_d;
  logic [1:0]    stg_bayer_q, stg_bayer_d, act_bayer_q, act_bayer_d;
  logic          stg_en_q, stg_en_d, act_en_q, act_en_d;
  logic          pend_q, pend_d;
  logic          start_q, start_d, done_q, done_d, applied_q, applied_d;
  logic          busy_q, busy_d;
  logic          apply;
  logic          href_hi;

  // Saturating increments; a line ending together with the frame still counts.
  assign line_inc = (line_q == '1) ? line_q : line_q + 1'b1;
  assign pix_inc  = (pix_q == '1) ? pix_q : pix_q + 1'b1;
  assign line_eff = href_fall ? line_inc : line_q;
  // Pixels are only counted while the frame is open (vsync low).
  assign href_hi  = href_lvl & ~vs_lvl;

  // State, counter, shadow and status registers.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT;
      frame_cnt_q <= '0;
      line_q      <= '0;
      pix_q       <= '0;
      errw_q      <= 1'b0;
      errh_q      <= 1'b0;
      stg_bayer_q <= BAYER;
      stg_en_q    <= EN_RST;
      act_bayer_q <= BAYER;
      act_en_q    <= EN_RST;
      pend_q      <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      applied_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      line_q      <= line_d;
      pix_q       <= pix_d;
      errw_q      <= errw_d;
      errh_q      <= errh_d;
      stg_bayer_q <= stg_bayer_d;
      stg_en_q    <= stg_en_d;
      act_bayer_q <= act_bayer_d;
      act_en_q    <= act_en_d;
      pend_q      <= pend_d;
      start_q     <= start_d;
      done_q      <= done_d;
      applied_q   <= applied_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state: FSM transitions, counting, error checks and config apply.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    line_d      = line_q;
    pix_d       = pix_q;
    errw_d      = errw_q;
    errh_d      = errh_q;
    stg_bayer_d = stg_bayer_q;
    stg_en_d    = stg_en_q;
    act_bayer_d = act_bayer_q;
    act_en_d    = act_en_q;
    pend_d      = pend_q;
    start_d     = 1'b0;
    done_d      = 1'b0;
    applied_d   = 1'b0;
    apply       = 1'b0;

    // Clear first so a same-cycle error set below takes priority.
    if (err_clr) begin
      errw_d = 1'b0;
      errh_d = 1'b0;
    end

    case (state_q)
      ST_WAIT: begin
        // First boundary only synchronises; the partial frame is dropped.
        if (vs_rise) begin
          state_d = ST_SYNC;
          apply   = 1'b1;
        end
      end
      ST_SYNC: begin
        if (vs_fall) begin
          state_d = ST_ACTIVE;
          line_d  = '0;
          pix_d   = '0;
        end
      end
      ST_ACTIVE: begin
        if (href_fall) begin
          if (pix_q != PW'(WIDTH)) errw_d = 1'b1;
          line_d = line_inc;
          pix_d  = '0;
        end else if (href_hi) begin
          pix_d = href_rise ? PW'(1) : pix_inc;
        end
        if (vs_rise) begin
          if (line_eff != LW'(HEIGHT)) errh_d = 1'b1;
          done_d      = 1'b1;
          start_d     = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = ST_SYNC;
          apply       = 1'b1;
        end
      end
      default: state_d = ST_WAIT;
    endcase

    // The old staging is applied before a same-cycle update overwrites it.
    if (apply && pend_q) begin
      act_bayer_d = stg_bayer_q;
      act_en_d    = stg_en_q;
      pend_d      = 1'b0;
      applied_d   = 1'b1;
    end
    if (cfg_update) begin
      stg_bayer_d = cfg_bayer;
      stg_en_d    = cfg_enable;
      pend_d      = 1'b1;
    end

    busy_d = (state_d == ST_ACTIVE);
  end

  assign act_bayer   = act_bayer_q;
  assign act_enable  = act_en_q;
  assign cfg_applied = applied_q;
  assign frame_start = start_q;
  assign frame_done  = done_q;
  assign frame_cnt   = frame_cnt_q;
  assign line_cnt    = line_q;
  assign pix_cnt     = pix_q;
  assign err_width   = errw_q;
  assign err_height  = errh_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_isp_frame_ctrl.sv
// Directed bench for isp_frame_ctrl with a frame-close scoreboard.
module tb_isp_frame_ctrl;
  import isp_frame_ctrl_pkg::*;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int PW = $clog2(W + 1);
  localparam int LW = $clog2(H + 1);

  logic          pclk = 1'b0;
  logic          rst_n, in_href, in_vsync, cfg_enable, cfg_update, err_clr;
  logic [1:0]    cfg_bayer;
  logic [1:0]    act_bayer;
  logic          act_enable, cfg_applied, frame_start, frame_done;
  logic [15:0]   frame_cnt;
  logic [LW-1:0] line_cnt;
  logic [PW-1:0] pix_cnt;
  logic          err_width, err_height, busy;

  isp_frame_ctrl #(
    .WIDTH(W), .HEIGHT(H), .BAYER(BAYER_RGGB), .EN_RST(1'b1)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .in_href(in_href), .in_vsync(in_vsync),
    .cfg_bayer(cfg_bayer), .cfg_enable(cfg_enable), .cfg_update(cfg_update),
    .err_clr(err_clr), .act_bayer(act_bayer), .act_enable(act_enable),
    .cfg_applied(cfg_applied), .frame_start(frame_start), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .line_cnt(line_cnt), .pix_cnt(pix_cnt),
    .err_width(err_width), .err_height(err_height), .busy(busy)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [15:0] fcnt;
    logic        errw;
    logic        errh;
    logic [1:0]  bayer;
    logic        en;
    logic        applied;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] m_fcnt;
  logic        m_errw, m_errh, m_pend, m_en, m_stage_en;
  logic [1:0]  m_bayer, m_stage;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic drive_line(input int n);
    in_href = 1'b1;
    tick(n);
    in_href = 1'b0;
    tick(3);
  endtask

  task automatic model_reset();
    m_fcnt = '0; m_errw = 1'b0; m_errh = 1'b0; m_pend = 1'b0;
    m_bayer = BAYER_RGGB; m_en = 1'b1; m_stage = BAYER_RGGB; m_stage_en = 1'b1;
  endtask

  task automatic vs_open();
    in_vsync = 1'b1;
    tick(4);
    in_vsync = 1'b0;
    tick(3);
  endtask

  // One active frame: nlines lines, optional short line, optional mid-frame
  // update (mid_bayer >= 0) and optional update coinciding with the closing rise.
  task automatic run_frame(input int nlines, input int short_idx, input int mid_bayer,
                           input bit upd_rise, input logic [1:0] upd_val);
    exp_t e;
    chk("busy_in_frame", 32'(busy), 32'd1);
    for (int i = 0; i < nlines; i++) begin
      if (i == short_idx) begin
        drive_line(W - 1);
        m_errw = 1'b1;
      end else begin
        drive_line(W);
      end
      if (i == 0 && mid_bayer >= 0) begin
        cfg_bayer = 2'(mid_bayer); cfg_enable = 1'b0; cfg_update = 1'b1;
        tick(1);
        cfg_update = 1'b0;
        m_stage = 2'(mid_bayer); m_stage_en = 1'b0; m_pend = 1'b1;
        tick(2);
        chk("act_bayer_held_after_update", 32'(act_bayer), 32'(m_bayer));
      end
    end
    chk("line_cnt_before_close", 32'(line_cnt), 32'(nlines));
    chk("pix_cnt_between_lines", 32'(pix_cnt), 32'd0);
    chk("act_bayer_before_close", 32'(act_bayer), 32'(m_bayer));
    if (nlines != H) m_errh = 1'b1;
    m_fcnt = m_fcnt + 16'd1;
    e.applied = m_pend;
    if (m_pend) begin
      m_bayer = m_stage; m_en = m_stage_en; m_pend = 1'b0;
    end
    if (upd_rise) begin
      m_stage = upd_val; m_stage_en = 1'b1; m_pend = 1'b1;
    end
    e.fcnt = m_fcnt; e.errw = m_errw; e.errh = m_errh; e.bayer = m_bayer; e.en = m_en;
    sb_q.push_back(e);
    in_vsync = 1'b1;
    tick(1);
    if (upd_rise) begin
      cfg_bayer = upd_val; cfg_enable = 1'b1; cfg_update = 1'b1;
    end
    tick(1);
    cfg_update = 1'b0;
    tick(1);
    chk("busy_after_close", 32'(busy), 32'd0);
    tick(1);
    in_vsync = 1'b0;
    tick(3);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) tick(1);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    m_errw = 1'b0; m_errh = 1'b0;
  endtask

  // Frame-close monitor: pulse alignment and scoreboard comparison.
  always @(negedge pclk) begin
    if (rst_n === 1'b1) begin
      if (frame_done || frame_start || cfg_applied) begin
        chk("frame_start_with_done", 32'(frame_start), 32'(frame_done));
        chk("cfg_applied_outside_close", 32'(cfg_applied & ~frame_done), 32'd0);
      end
      if (frame_done) begin
        chk("frame_done_expected", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          chk("close_frame_cnt", 32'(frame_cnt), 32'(mon_e.fcnt));
          chk("close_err_width", 32'(err_width), 32'(mon_e.errw));
          chk("close_err_height", 32'(err_height), 32'(mon_e.errh));
          chk("close_act_bayer", 32'(act_bayer), 32'(mon_e.bayer));
          chk("close_act_enable", 32'(act_enable), 32'(mon_e.en));
          chk("close_cfg_applied", 32'(cfg_applied), 32'(mon_e.applied));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before the end of the sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_href = 1'b0; in_vsync = 1'b0;
    cfg_bayer = 2'd0; cfg_enable = 1'b1; cfg_update = 1'b0; err_clr = 1'b0;
    model_reset();
    tick(3);
    chk("rst_act_bayer", 32'(act_bayer), 32'(BAYER_RGGB));
    chk("rst_act_enable", 32'(act_enable), 32'd1);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_pulses", 32'({frame_start, frame_done, cfg_applied}), 32'd0);
    chk("rst_errors", 32'({err_width, err_height}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick(2);

    vs_open();
    chk("no_frame_cnt_on_first_rise", 32'(frame_cnt), 32'd0);
    run_frame(H, -1, -1, 1'b0, 2'd0);
    run_frame(H, -1, -1, 1'b0, 2'd0);
    run_frame(H, -1, 3, 1'b0, 2'd0);
    run_frame(H, 2, -1, 1'b0, 2'd0);
    run_frame(H, -1, -1, 1'b0, 2'd0);
    drain();
    pulse_err_clr();
    chk("err_width_cleared", 32'(err_width), 32'd0);
    run_frame(H - 1, -1, -1, 1'b0, 2'd0);
    drain();
    pulse_err_clr();
    chk("err_height_cleared", 32'(err_height), 32'd0);
    run_frame(H, -1, -1, 1'b1, BAYER_GRBG);
    run_frame(H, -1, -1, 1'b0, 2'd0);
    drain();
    chk("frame_cnt_total", 32'(frame_cnt), 32'(m_fcnt));

    in_href = 1'b1;
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("midrst_act_bayer", 32'(act_bayer), 32'(BAYER_RGGB));
    chk("midrst_act_enable", 32'(act_enable), 32'd1);
    chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("midrst_counts", 32'({line_cnt, pix_cnt}), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    model_reset();
    @(negedge pclk);
    rst_n = 1'b1;
    tick(4);
    in_href = 1'b0;
    tick(3);
    drive_line(W - 2);
    drive_line(W);
    vs_open();
    chk("partial_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("partial_errors", 32'({err_width, err_height}), 32'd0);
    run_frame(H, -1, -1, 1'b0, 2'd0);
    drain();
    chk("post_reset_frame_cnt", 32'(frame_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
